// File: rtl/counter_pkg.sv
// Shared definitions for the parameterised up/down counter.
package counter_pkg;

  // Default data width of all signed data ports.
  localparam int DEFAULT_WIDTH = 8;

  // Limit-handling modes. 2'b11 behaves like saturate.
  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

endpackage

// File: rtl/counter_limit_check.sv
// Combinational next-value computation, limit comparison and load clamp.
// The step is evaluated in WIDTH+2 bits so q +/- b never wraps before it is
// compared with the limits.
module counter_limit_check
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH-1:0] q,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    dn,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] lo_lim,
  input  logic signed [WIDTH-1:0] hi_lim,
  output logic signed [WIDTH-1:0] count_val,
  output logic signed [WIDTH-1:0] load_val,
  output logic                    lim_ovf,
  output logic                    lim_unf,
  output logic                    halt_hit,
  output logic                    cfg_err,
  output logic                    at_max,
  output logic                    at_min
);

  localparam int XW = WIDTH + 2;

  logic signed [XW-1:0] q_x;
  logic signed [XW-1:0] b_x;
  logic signed [XW-1:0] lo_x;
  logic signed [XW-1:0] hi_x;
  logic signed [XW-1:0] sum_x;

  // Extended-precision step and the value q takes after a limit decision.
  always_comb begin
    q_x      = {{2{q[WIDTH-1]}}, q};
    b_x      = {{2{b[WIDTH-1]}}, b};
    lo_x     = {{2{lo_lim[WIDTH-1]}}, lo_lim};
    hi_x     = {{2{hi_lim[WIDTH-1]}}, hi_lim};
    sum_x    = dn ? (q_x - b_x) : (q_x + b_x);
    lim_ovf  = (sum_x > hi_x);
    lim_unf  = (sum_x < lo_x);
    halt_hit = (lim_ovf || lim_unf) && (mode == MODE_HALT);
    count_val = sum_x[WIDTH-1:0];
    if (lim_ovf) begin
      case (mode)
        MODE_WRAP: count_val = lo_lim;
        MODE_HALT: count_val = q;
        default:   count_val = hi_lim;
      endcase
    end else if (lim_unf) begin
      case (mode)
        MODE_WRAP: count_val = hi_lim;
        MODE_HALT: count_val = q;
        default:   count_val = lo_lim;
      endcase
    end
  end

  // Load value clamped into lo_lim..hi_lim, plus the status flags.
  always_comb begin
    if (a < lo_lim)      load_val = lo_lim;
    else if (a > hi_lim) load_val = hi_lim;
    else                 load_val = a;
    cfg_err = (lo_lim > hi_lim);
    at_max  = (q == hi_lim);
    at_min  = (q == lo_lim);
  end

endmodule

// File: rtl/param_updown_counter.sv
// Signed up/down counter with inclusive limits and wrap/saturate/halt
// handling. Holds the registers and the rst > load > count > hold priority;
// all arithmetic lives in counter_limit_check.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int                      WIDTH   = DEFAULT_WIDTH,
  parameter logic signed [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    up,
  input  logic                    dn,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] lo_lim,
  input  logic signed [WIDTH-1:0] hi_lim,
  output logic signed [WIDTH-1:0] q,
  output logic                    ovf,
  output logic                    unf,
  output logic                    halted,
  output logic                    at_max,
  output logic                    at_min,
  output logic                    cfg_err
);

  logic signed [WIDTH-1:0] count_val;
  logic signed [WIDTH-1:0] load_val;
  logic                    lim_ovf;
  logic                    lim_unf;
  logic                    halt_hit;
  logic                    step;

  counter_limit_check #(.WIDTH(WIDTH)) u_check (
    .q         (q),
    .a         (a),
    .b         (b),
    .dn        (dn),
    .mode      (mode),
    .lo_lim    (lo_lim),
    .hi_lim    (hi_lim),
    .count_val (count_val),
    .load_val  (load_val),
    .lim_ovf   (lim_ovf),
    .lim_unf   (lim_unf),
    .halt_hit  (halt_hit),
    .cfg_err   (cfg_err),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  // A step is requested only when exactly one of up/dn is high.
  assign step = up ^ dn;

  // Count register and sticky/pulse flags; ovf/unf default low every edge
  // so they are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= RST_VAL;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      halted <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      if (cfg_err) begin
        // Inconsistent limits: freeze everything until they are fixed.
      end else if (load) begin
        q      <= load_val;
        halted <= 1'b0;
      end else if (step && !halted) begin
        q   <= count_val;
        ovf <= lim_ovf;
        unf <= lim_unf;
        if (halt_hit) halted <= 1'b1;
      end
    end
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of all signed data ports.
REQ-002 SHALL have parameter RST_VAL, default 0, meaning signed value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port load  input  1  load a into q.
REQ-006 SHALL have port a  input  WIDTH  signed load value.
REQ-007 SHALL have port b  input  WIDTH  signed step, added on up and subtracted on dn.
REQ-008 SHALL have port up  input  1  count request, q plus b.
REQ-009 SHALL have port dn  input  1  count request, q minus b.
REQ-010 SHALL have port mode  input  2  limit handling: 00 wrap, 01 saturate, 10 halt, 11 treated as saturate.
REQ-011 SHALL have port lo_lim  input  WIDTH  signed lower bound, inclusive.
REQ-012 SHALL have port hi_lim  input  WIDTH  signed upper bound, inclusive.
REQ-013 SHALL have port q  output  WIDTH  signed registered count.
REQ-014 SHALL have port ovf  output  1  one-cycle pulse when the next value is greater than hi_lim.
REQ-015 SHALL have port unf  output  1  one-cycle pulse when the next value is less than lo_lim.
REQ-016 SHALL have port halted  output  1  sticky flag; counting is frozen.
REQ-017 SHALL have port at_max and at_min  output  1 each  combinational flags for q equal to hi_lim and q equal to lo_lim.
REQ-018 SHALL have port cfg_err  output  1  combinational flag for lo_lim greater than hi_lim.

Function
REQ-019 Priority SHALL be rst, then load, then count, then hold.
REQ-020 A count step SHALL occur only when up XOR dn is high; up and dn both high, or both low, SHALL hold q.
REQ-021 The next value SHALL be computed sign-extended to WIDTH+2 bits, so intermediate results never wrap.
REQ-022 If the next value is in the range lo_lim..hi_lim, q SHALL take it with a latency of 1 cycle.
REQ-023 Limit action on next value greater than hi_lim:
- wrap: q becomes lo_lim
- saturate: q becomes hi_lim
- halt: q holds and halted is set
- all modes: ovf pulses for exactly 1 cycle
REQ-024 Limit action on next value less than lo_lim:
- wrap: q becomes hi_lim
- saturate: q becomes lo_lim
- halt: q holds and halted is set
- all modes: unf pulses for exactly 1 cycle
REQ-025 The sign of b SHALL be honoured: up with a negative b decrements and can cause unf.
REQ-026 While halted is 1, count requests SHALL be ignored and ovf and unf SHALL stay 0.
REQ-027 Load SHALL clear halted.
REQ-028 Load SHALL clamp a into the range lo_lim..hi_lim and SHALL NOT pulse ovf or unf.
REQ-029 While cfg_err is 1, counting and load SHALL hold q with ovf and unf at 0; rst still applies.
REQ-030 Changes to mode or the limits SHALL take effect on the next edge; q is not re-clamped until the next load or count.

Reset
REQ-031 On rst, q SHALL become RST_VAL, and ovf, unf and halted SHALL become 0, at the same edge.
REQ-032 Reset SHALL override any in-progress count or halt in the cycle it is asserted.
REQ-033 RST_VAL SHALL be loaded even if it lies outside lo_lim..hi_lim.

Structure
REQ-034 Mode encodings (MODE_WRAP, MODE_SAT, MODE_HALT) and the default WIDTH SHALL live in a shared package, counter_pkg.
REQ-035 The next-value computation and limit comparison SHALL be a combinational sub-module, counter_limit_check.
REQ-036 counter_limit_check SHALL output the clamped or wrapped value plus the ovf and unf decisions.
REQ-037 The top level SHALL hold only the registers and the priority logic.

Verification (WIDTH=8)
REQ-038 Wrap underflow:
- stimulus: load 29, b=-17, up=1, lo=-128, hi=127, mode wrap
- response: q steps 12, -5, -22 … -124 over 9 steps; on the 10th step unf pulses and q=127.
REQ-039 Saturate overflow:
- stimulus: load 29, b=17, hi=100, mode saturate
- response: q steps 46, 63, 80, 97; then ovf pulses 1 cycle, q=100 and at_max=1.
REQ-040 Halt:
- stimulus: same as REQ-039 but mode halt
- response: q holds at 97 and halted=1; further up is ignored; load 5 gives q=5 and halted=0.
REQ-041 Simultaneous requests and load clamp:
- up=dn=1 for 3 cycles gives q unchanged
- load 120 with hi=100 gives q=100 and no ovf
REQ-042 Configuration error:
- stimulus: lo=10, hi=5
- response: cfg_err=1; up and load leave q unchanged.
REQ-043 Reset mid-count:
- stimulus: rst during counting with halted=1
- response: next edge gives q=RST_VAL (0), and halted, ovf and unf all 0.
